load_extend_ctrl: RTL and testbench



---
 rtl/load_extend_ctrl.sv | 116 +++++++++++
 tb/tb_load_extend_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_extend_ctrl.sv
// Load sequencer: issues one request/acknowledge read on the data-memory port,
// then selects the byte lane and zero- or sign-extends the result.
//
// state | meaning
// IDLE  | waiting for start; bad commands complete straight away with err
// REQ   | mem_req held high until mem_ack or the wait budget runs out
// DONE  | one-cycle done pulse, err valid, then back to IDLE
module load_extend_ctrl #(
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [15:0]       addr,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_req,
    output logic [15:0]       mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } stateT;

    localparam logic [1:0] OP_LW  = 2'b00;
    localparam logic [1:0] OP_LBU = 2'b01;
    localparam logic [1:0] OP_LB  = 2'b10;

    stateT             state;
    stateT             stateNext;
    logic [1:0]        opQ;
    logic [15:0]       addrQ;
    logic [7:0]        waitCnt;
    logic              errQ;
    logic [DATA_W-1:0] rdataQ;
    logic              cmdBad;
    logic [7:0]        laneByte;
    logic [DATA_W-1:0] extData;

    assign cmdBad = (op == 2'b11) || ((op == OP_LW) && addr[0]);

    // Little-endian lane select on the latched address.
    assign laneByte = addrQ[0] ? mem_rdata[15:8] : mem_rdata[7:0];

    always_comb begin
        extData = mem_rdata;
        case (opQ)
            OP_LW:   extData = mem_rdata;
            OP_LBU:  extData = {8'h00, laneByte};
            OP_LB:   extData = {{8{laneByte[7]}}, laneByte};
            default: extData = mem_rdata;
        endcase
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (start) stateNext = cmdBad ? DONE : REQ;
            // Ack in the last budgeted cycle still wins over the timeout.
            REQ:  if (mem_ack || (waitCnt == 8'd0)) stateNext = DONE;
            DONE: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            opQ     <= 2'b00;
            addrQ   <= 16'h0000;
            waitCnt <= 8'd0;
            errQ    <= 1'b0;
            rdataQ  <= '0;
        end else begin
            state <= stateNext;
            case (state)
                IDLE: begin
                    if (start) begin
                        opQ     <= op;
                        addrQ   <= addr;
                        waitCnt <= 8'(TIMEOUT - 1);
                        errQ    <= cmdBad;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        rdataQ <= extData;
                        errQ   <= 1'b0;
                    end else if (waitCnt == 8'd0) begin
                        errQ <= 1'b1;
                    end else begin
                        waitCnt <= waitCnt - 8'd1;
                    end
                end
                DONE: errQ <= 1'b0;
                default: errQ <= 1'b0;
            endcase
        end
    end

    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign err      = errQ;
    assign rdata    = rdataQ;
    assign mem_req  = (state == REQ);
    assign mem_addr = {addrQ[15:1], 1'b0};

endmodule

// File: tb/tb_load_extend_ctrl.sv
// Self-checking bench for load_extend_ctrl: a scoreboard queue holds the expected
// completion of every issued load and is drained when the DUT pulses done.
module tb_load_extend_ctrl;

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        int          lat;
        int          reqCycles;
        logic [15:0] memAddr;
    } expT;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [15:0] addr = 16'h0000;
    logic        busy, done, err;
    logic [15:0] rdata;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = 16'h0000;

    int checks = 0;
    int errors = 0;
    expT sb[$];
    logic [15:0] lastRdata = 16'h0000;

    load_extend_ctrl #(.DATA_W(16), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .addr(addr),
        .busy(busy), .done(done), .err(err), .rdata(rdata),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model of a completed load.
    function automatic logic [15:0] model(input logic [1:0] o, input logic [15:0] a,
                                          input logic [15:0] d);
        logic [7:0] b;
        b = a[0] ? d[15:8] : d[7:0];
        case (o)
            2'b01:   return {8'h00, b};
            2'b10:   return {{8{b[7]}}, b};
            default: return d;
        endcase
    endfunction

    // Expected entry for a load; ackAfter < 0 means memory never acks.
    task automatic pushExp(input logic [1:0] o, input logic [15:0] a, input logic [15:0] d,
                           input int ackAfter);
        expT e;
        e.memAddr = {a[15:1], 1'b0};
        if (o == 2'b11 || (o == 2'b00 && a[0])) begin
            e.rdata = lastRdata; e.err = 1'b1; e.lat = 0; e.reqCycles = 0;
        end else if (ackAfter < 0 || ackAfter > 7) begin
            e.rdata = lastRdata; e.err = 1'b1; e.lat = 8; e.reqCycles = 8;
        end else begin
            e.rdata = model(o, a, d); e.err = 1'b0;
            e.lat = ackAfter + 1; e.reqCycles = ackAfter + 1;
            lastRdata = e.rdata;
        end
        sb.push_back(e);
    endtask

    // Drives one command and plays the memory; returns what was observed at done.
    task automatic runLoad(input logic [1:0] o, input logic [15:0] a, input logic [15:0] d,
                           input int ackAfter, input bit pokeStart,
                           output logic [15:0] obsRdata, output logic obsErr,
                           output int lat, output int reqCycles,
                           output logic [15:0] obsMemAddr, output bit timedOut);
        start = 1'b1; op = o; addr = a;
        tick();
        start = 1'b0;
        lat = 0; reqCycles = 0; timedOut = 1'b1; obsMemAddr = 16'h0000;
        obsRdata = 16'h0000; obsErr = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                timedOut = 1'b0;
                obsRdata = rdata;
                obsErr = err;
                start = 1'b0;
                break;
            end
            if (mem_req) begin
                reqCycles++;
                obsMemAddr = mem_addr;
                mem_ack = (reqCycles - 1 == ackAfter);
                mem_rdata = mem_ack ? d : 16'hDEAD;
                if (pokeStart) begin
                    start = 1'b1; op = 2'b11; addr = 16'h0003;
                end
            end
            tick();
            lat++;
            mem_ack = 1'b0;
        end
    endtask

    task automatic checkLoad(input string name, input logic [15:0] r, input logic e,
                             input int lat, input int rc, input logic [15:0] ma,
                             input bit to);
        expT x;
        checks++;
        if (to || sb.size() == 0) begin
            errors++;
            $display("FAIL %s_timeout: no done within cycle budget", name);
            return;
        end
        x = sb.pop_front();
        checks++;
        if (r !== x.rdata) begin
            errors++; $display("FAIL %s_rdata: got %h expected %h", name, r, x.rdata);
        end
        checks++;
        if (e !== x.err) begin
            errors++; $display("FAIL %s_err: got %b expected %b", name, e, x.err);
        end
        checks++;
        if (lat != x.lat) begin
            errors++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, x.lat);
        end
        checks++;
        if (rc != x.reqCycles) begin
            errors++; $display("FAIL %s_reqcycles: got %0d expected %0d", name, rc, x.reqCycles);
        end
        if (x.reqCycles > 0) begin
            checks++;
            if (ma !== x.memAddr) begin
                errors++; $display("FAIL %s_memaddr: got %h expected %h", name, ma, x.memAddr);
            end
        end
        tick();
        checks++;
        if ({done, busy, err} !== 3'b000) begin
            errors++; $display("FAIL %s_return_idle: done/busy/err got %b expected 000",
                               name, {done, busy, err});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mem_ack = 1'b1;
        tick(); tick();
        rst = 1'b0;
        mem_ack = 1'b0;
        checks++;
        if ({busy, done, err, mem_req} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got %b expected 0000", {busy, done, err, mem_req});
        end
        checks++;
        if (rdata !== 16'h0000 || mem_addr !== 16'h0000) begin
            errors++; $display("FAIL reset_data: rdata %h mem_addr %h expected 0000 0000",
                               rdata, mem_addr);
        end
        lastRdata = 16'h0000;
    endtask

    task automatic test_lbu();
        logic [15:0] r, ma; logic e; int lat, rc; bit to;
        pushExp(2'b01, 16'h0010, 16'h3480, 0);
        runLoad(2'b01, 16'h0010, 16'h3480, 0, 1'b0, r, e, lat, rc, ma, to);
        checkLoad("lbu", r, e, lat, rc, ma, to);
    endtask

    task automatic test_lb();
        logic [15:0] r, ma; logic e; int lat, rc; bit to;
        pushExp(2'b10, 16'h0011, 16'h80FF, 3);
        runLoad(2'b10, 16'h0011, 16'h80FF, 3, 1'b0, r, e, lat, rc, ma, to);
        checkLoad("lb_neg", r, e, lat, rc, ma, to);
        pushExp(2'b10, 16'h0011, 16'h0F00, 3);
        runLoad(2'b10, 16'h0011, 16'h0F00, 3, 1'b0, r, e, lat, rc, ma, to);
        checkLoad("lb_pos", r, e, lat, rc, ma, to);
    endtask

    task automatic test_lw();
        logic [15:0] r, ma; logic e; int lat, rc; bit to;
        pushExp(2'b00, 16'h0020, 16'hBEEF, 0);
        runLoad(2'b00, 16'h0020, 16'hBEEF, 0, 1'b0, r, e, lat, rc, ma, to);
        checkLoad("lw", r, e, lat, rc, ma, to);
        pushExp(2'b00, 16'h0021, 16'h1111, 0);
        runLoad(2'b00, 16'h0021, 16'h1111, 0, 1'b0, r, e, lat, rc, ma, to);
        checkLoad("lw_misaligned", r, e, lat, rc, ma, to);
        pushExp(2'b11, 16'h0022, 16'h2222, 0);
        runLoad(2'b11, 16'h0022, 16'h2222, 0, 1'b0, r, e, lat, rc, ma, to);
        checkLoad("reserved_op", r, e, lat, rc, ma, to);
    endtask

    task automatic test_timeout();
        logic [15:0] r, ma; logic e; int lat, rc; bit to;
        pushExp(2'b01, 16'h0030, 16'h7777, -1);
        runLoad(2'b01, 16'h0030, 16'h7777, -1, 1'b0, r, e, lat, rc, ma, to);
        checkLoad("timeout", r, e, lat, rc, ma, to);
        pushExp(2'b10, 16'h0030, 16'h00C3, 7);
        runLoad(2'b10, 16'h0030, 16'h00C3, 7, 1'b0, r, e, lat, rc, ma, to);
        checkLoad("ack_last_cycle", r, e, lat, rc, ma, to);
    endtask

    task automatic test_busy_ignore();
        logic [15:0] r, ma; logic e; int lat, rc; bit to;
        int spurious;
        pushExp(2'b01, 16'h0041, 16'hA55A, 2);
        runLoad(2'b01, 16'h0041, 16'hA55A, 2, 1'b1, r, e, lat, rc, ma, to);
        checkLoad("busy_ignore", r, e, lat, rc, ma, to);
        spurious = 0;
        for (int i = 0; i < 4; i++) begin
            if (done || busy) spurious++;
            tick();
        end
        checks++;
        if (spurious != 0) begin
            errors++; $display("FAIL busy_ignore_spurious: got %0d busy/done cycles expected 0",
                               spurious);
        end
    endtask

    task automatic test_reset_mid_req();
        logic [15:0] r, ma; logic e; int lat, rc; bit to;
        start = 1'b1; op = 2'b01; addr = 16'h0044;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if (mem_req !== 1'b1) begin
            errors++; $display("FAIL midreq_precond: mem_req got %b expected 1", mem_req);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({mem_req, busy, done, err} !== 4'b0000 || rdata !== 16'h0000) begin
            errors++; $display("FAIL midreq_reset: req/busy/done/err %b rdata %h expected 0000 0000",
                               {mem_req, busy, done, err}, rdata);
        end
        lastRdata = 16'h0000;
        pushExp(2'b00, 16'h0050, 16'h1234, 1);
        runLoad(2'b00, 16'h0050, 16'h1234, 1, 1'b0, r, e, lat, rc, ma, to);
        checkLoad("after_reset", r, e, lat, rc, ma, to);
    endtask

    initial begin
        test_reset();
        test_lbu();
        test_lb();
        test_lw();
        test_timeout();
        test_busy_ignore();
        test_reset_mid_req();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
